// File: rtl/um_loader_pkg.sv
// Shared widths, pad value and loader state encoding for the unsorted-memory loader.
package um_loader_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int ELEMENT_NUM      = 16;
  localparam int LOG2_ELEMENT_NUM = 4;
  localparam int CNT_W            = LOG2_ELEMENT_NUM + 1;

  localparam logic [DATA_WIDTH-1:0]       PAD_VALUE = '1;
  localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_ADDR = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PAD   = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/um_loader_if.sv
// Element stream in, unsorted-memory write port and sorter handshake out.
interface um_loader_if;
  import um_loader_pkg::*;

  logic                        s_valid;
  logic                        s_ready;
  logic [DATA_WIDTH-1:0]       s_data;
  logic                        s_last;
  logic                        um_wr_en;
  logic [LOG2_ELEMENT_NUM-1:0] um_addr;
  logic [DATA_WIDTH-1:0]       um_wr_data;
  logic                        sort_start;
  logic                        sort_done;
  logic [CNT_W-1:0]            elem_cnt;
  logic                        busy;

  modport slave (
    input  s_valid, s_data, s_last, sort_done,
    output s_ready, um_wr_en, um_addr, um_wr_data, sort_start, elem_cnt, busy
  );

  modport master (
    output s_valid, s_data, s_last, sort_done,
    input  s_ready, um_wr_en, um_addr, um_wr_data, sort_start, elem_cnt, busy
  );

endinterface

// File: rtl/um_loader.sv
// Loads one batch into unsorted memory, pads short batches, kicks the sorter, waits for done.
// One cycle accept-to-write latency; s_ready drops outside LOAD until sort_done returns.
module um_loader
  import um_loader_pkg::*;
(
  input  logic        clk_mn,
  input  logic        rst,
  um_loader_if.slave  lif
);

  state_e                      state_q, state_d;
  logic [LOG2_ELEMENT_NUM-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        wr_en_q, wr_en_d;
  logic [LOG2_ELEMENT_NUM-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic                        start_q, start_d;
  logic                        accept;

  assign lif.s_ready = (state_q == ST_LOAD) & ~rst;
  assign accept      = lif.s_valid & lif.s_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    start_d  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          wr_en_d = 1'b1;
          addr_d  = wr_ptr_q;
          wdata_d = lif.s_data;
          // wr_ptr is zero only on the first beat of a batch
          cnt_d   = (wr_ptr_q == '0) ? CNT_W'(1) : cnt_q + CNT_W'(1);
          if (wr_ptr_q == LAST_ADDR) begin
            state_d = ST_START;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (lif.s_last) state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        wr_en_d = 1'b1;
        addr_d  = wr_ptr_q;
        wdata_d = PAD_VALUE;
        if (wr_ptr_q == LAST_ADDR) state_d = ST_START;
        else                       wr_ptr_d = wr_ptr_q + 1'b1;
      end
      ST_START: begin
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lif.sort_done) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk_mn) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      start_q  <= start_d;
    end
  end

  assign lif.um_wr_en   = wr_en_q;
  assign lif.um_addr    = addr_q;
  assign lif.um_wr_data = wdata_q;
  assign lif.sort_start = start_q;
  assign lif.elem_cnt   = cnt_q;
  assign lif.busy       = (state_q != ST_LOAD);

endmodule

// File: tb/tb_um_loader.sv
// Scoreboard bench: stimulus queues expected writes and batch counts, a monitor pops and compares.
module tb_um_loader;
  import um_loader_pkg::*;

  typedef struct packed {
    logic [LOG2_ELEMENT_NUM-1:0] addr;
    logic [DATA_WIDTH-1:0]       data;
  } wr_t;

  logic clk_mn = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_mn = ~clk_mn;

  um_loader_if ifc();
  um_loader dut (.clk_mn(clk_mn), .rst(rst), .lif(ifc));

  wr_t exp_wr_q[$];
  int  exp_cnt_q[$];
  int  errors = 0;
  int  checks = 0;
  int  start_cnt = 0;
  int  starts_expected = 0;
  bit  prev_wr15 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_mn) begin : monitor
    wr_t w;
    int  c;
    if (ifc.um_wr_en === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none", ifc.um_addr, ifc.um_wr_data);
      end else begin
        w = exp_wr_q.pop_front();
        chk("wr_addr", 32'(ifc.um_addr), 32'(w.addr));
        chk("wr_data", 32'(ifc.um_wr_data), 32'(w.data));
      end
    end
    if (ifc.sort_start === 1'b1) begin
      start_cnt++;
      chk("start_after_addr15", 32'(prev_wr15), 1);
      chk("start_busy", 32'(ifc.busy), 1);
      if (exp_cnt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_start: got elem_cnt %0d expected no start", ifc.elem_cnt);
      end else begin
        c = exp_cnt_q.pop_front();
        chk("elem_cnt_at_start", 32'(ifc.elem_cnt), 32'(c));
      end
    end
    if (dut.state_q == ST_PAD)  chk("ready_low_in_pad", 32'(ifc.s_ready), 0);
    if (dut.state_q == ST_WAIT) chk("ready_low_in_wait", 32'(ifc.s_ready), 0);
    prev_wr15 = (ifc.um_wr_en === 1'b1) && (ifc.um_addr == LAST_ADDR);
  end

  task automatic pulse_done();
    @(negedge clk_mn); ifc.sort_done = 1'b1;
    @(negedge clk_mn); ifc.sort_done = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input bit last, output bit ok);
    @(negedge clk_mn);
    ifc.s_valid = 1'b1; ifc.s_data = d; ifc.s_last = last;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ifc.s_ready === 1'b1) begin
        @(posedge clk_mn);
        ok = 1'b1;
        break;
      end
      @(negedge clk_mn);
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // abort: no pads/start expected (reset lands mid-pad); spurious: sort_done pulse in a LOAD gap
  task automatic batch(input int n, input int base, input int step, input bit gaps,
                       input bit abort, input bit done, input bit chk_first, input bit spurious);
    bit ok;
    logic [7:0] d;
    wr_t w;
    int target;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk_mn); ifc.s_valid = 1'b0; ifc.s_last = 1'b0;
        end
      end
      if (spurious && i == 3) begin
        @(negedge clk_mn); ifc.s_valid = 1'b0;
        chk("state_load_at_spurious_done", 32'(dut.state_q), 32'(ST_LOAD));
        ifc.sort_done = 1'b1;
        @(negedge clk_mn); ifc.sort_done = 1'b0;
      end
      d = 8'(base + step * i);
      send_beat(d, (i == n - 1), ok);
      if (ok) begin
        w.addr = 4'(i); w.data = d;
        exp_wr_q.push_back(w);
        if (i == 0 && chk_first) begin
          #1 chk("elem_cnt_first_accept", 32'(ifc.elem_cnt), 1);
        end
      end
    end
    @(negedge clk_mn); ifc.s_valid = 1'b0; ifc.s_last = 1'b0;
    if (abort) return;
    for (int a = n; a < ELEMENT_NUM; a++) begin
      w.addr = 4'(a); w.data = PAD_VALUE;
      exp_wr_q.push_back(w);
    end
    exp_cnt_q.push_back(n);
    starts_expected++;
    target = starts_expected;
    for (int k = 0; k < 100 && start_cnt < target; k++) @(negedge clk_mn);
    chk("sort_start_seen", 32'(start_cnt), 32'(target));
    repeat (3) @(negedge clk_mn);
    chk("single_start_pulse", 32'(start_cnt), 32'(target));
    chk("elem_cnt_in_wait", 32'(ifc.elem_cnt), 32'(n));
    if (done) pulse_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.s_last = 1'b0; ifc.sort_done = 1'b0;
    repeat (2) @(negedge clk_mn);
    chk("rst_wr_en", 32'(ifc.um_wr_en), 0);
    chk("rst_addr", 32'(ifc.um_addr), 0);
    chk("rst_wr_data", 32'(ifc.um_wr_data), 0);
    chk("rst_start", 32'(ifc.sort_start), 0);
    chk("rst_elem_cnt", 32'(ifc.elem_cnt), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_ready", 32'(ifc.s_ready), 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(ifc.s_ready), 1);

    // full batch 16..1, short batch of 5, single element
    batch(16, 16, -1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    batch(5, 8'hA1, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    batch(1, 8'h42, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // backpressure: valid held high through WAIT
    batch(16, 0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_mn);
    ifc.s_valid = 1'b1; ifc.s_data = 8'h77; ifc.s_last = 1'b0;
    repeat (10) begin
      @(negedge clk_mn);
      chk("bp_ready_low", 32'(ifc.s_ready), 0);
      chk("bp_no_write", 32'(ifc.um_wr_en), 0);
    end
    ifc.s_valid = 1'b0;
    ifc.sort_done = 1'b1;
    @(negedge clk_mn); ifc.sort_done = 1'b0;
    chk("bp_back_to_load", 32'(dut.state_q), 32'(ST_LOAD));
    batch(3, 8'h77, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // reset while padding at wr_ptr=9
    batch(9, 8'h30, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("midpad_state", 32'(dut.state_q), 32'(ST_PAD));
    chk("midpad_ptr", 32'(dut.wr_ptr_q), 9);
    rst = 1'b1;
    @(negedge clk_mn);
    chk("midpad_rst_wr_en", 32'(ifc.um_wr_en), 0);
    chk("midpad_rst_addr", 32'(ifc.um_addr), 0);
    chk("midpad_rst_data", 32'(ifc.um_wr_data), 0);
    chk("midpad_rst_start", 32'(ifc.sort_start), 0);
    chk("midpad_rst_cnt", 32'(ifc.elem_cnt), 0);
    chk("midpad_rst_busy", 32'(ifc.busy), 0);
    chk("midpad_rst_state", 32'(dut.state_q), 32'(ST_LOAD));
    rst = 1'b0;
    @(negedge clk_mn);
    chk("midpad_no_pending", 32'(exp_wr_q.size()), 0);
    batch(16, 8'h80, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // bubbles plus a spurious sort_done while loading
    batch(12, 8'h10, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    repeat (5) @(negedge clk_mn);
    chk("final_wr_queue_empty", 32'(exp_wr_q.size()), 0);
    chk("final_cnt_queue_empty", 32'(exp_cnt_q.size()), 0);
    chk("final_start_count", 32'(start_cnt), 32'(starts_expected));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/um_loader.md
Name: um_loader

Overview:
- Upstream feeder for the unsorted-memory stage of the comparison-free sorter.
- Accepts a valid/ready element stream and writes each element into consecutive unsorted-memory addresses.
- Pads short batches up to ELEMENT_NUM with a fixed value, pulses sort_start once the memory is complete, then blocks input until the sorter reports completion.
- Sits between the external input interface and the unsorted memory write port; the parent muxes its address onto the memory address bus while busy loading.

Parameters:
- DATA_WIDTH, 8, element width in bits (matches `DATA_WIDTH).
- ELEMENT_NUM, 16, elements per batch; power of two, at least 2 (matches `ELEMENT_NUM).
- LOG2_ELEMENT_NUM, 4, address width (matches `LOG2_ELEMENT_NUM).
- PAD_VALUE, all-ones (2^DATA_WIDTH-1), value written to unfilled slots of a short batch.

Ports:
- clk_mn  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input element valid
- s_ready  out  1  loader can accept an element
- s_data  in  DATA_WIDTH  input element
- s_last  in  1  marks final element of a batch; qualified by s_valid&s_ready
- um_wr_en  out  1  write strobe to unsorted memory (in_valid)
- um_addr  out  LOG2_ELEMENT_NUM  write address (UM_addr)
- um_wr_data  out  DATA_WIDTH  write data (in_data)
- sort_start  out  1  one-cycle pulse: memory full, begin sort
- sort_done  in  1  sorter finished; loader may accept next batch
- elem_cnt  out  LOG2_ELEMENT_NUM+1  real (non-pad) elements in current batch, range 1..ELEMENT_NUM
- busy  out  1  high in every state except LOAD

Behaviour:
- Reset (rst=1 at a clk_mn edge), effective even mid-batch or mid-pad:
  - state=LOAD, wr_ptr=0.
  - um_wr_en=0, um_addr=0, um_wr_data=0, sort_start=0, elem_cnt=0, busy=0.
  - No memory write is issued for the reset cycle.
- Handshake: accept = s_valid & s_ready. s_ready = (state==LOAD) & ~rst; it is combinational from state only and never depends on s_valid.
- All um_* outputs and sort_start are registered. A write occurs on the edge after the cycle that produced it, giving one cycle of latency from accept to um_wr_en.
- States:
  - LOAD: on accept, register um_wr_en=1, um_addr=wr_ptr, um_wr_data=s_data, and increment the count.
    - If wr_ptr==ELEMENT_NUM-1, go to START; no pad is written even if s_last=1.
    - Else if s_last, go to PAD with wr_ptr+1.
    - Else wr_ptr+1 and stay in LOAD.
    - With no accept, um_wr_en=0.
  - PAD: s_ready=0. Each cycle write PAD_VALUE at wr_ptr and increment. After the write at ELEMENT_NUM-1, go to START. Exactly ELEMENT_NUM-elem_cnt pad writes are issued.
  - START: um_wr_en=0. sort_start is asserted for exactly one cycle, in the cycle immediately after the final um_wr_en pulse, so the memory holds all data. Then go to WAIT.
  - WAIT: s_ready=0. On sort_done=1, go to LOAD with wr_ptr=0.
- sort_done is ignored in LOAD, PAD and START.
- elem_cnt:
  - Cleared to 0 on reset.
  - Reset to 1 on the first accept of a new batch, then incremented on each accept.
  - Stable from the final accept until the first accept of the next batch. The sorter samples it during WAIT.
- wr_ptr never wraps silently: the compare against ELEMENT_NUM-1 terminates LOAD and PAD.
- No address is ever written twice per batch.
- s_data and s_last are don't-care when accept=0.

Decomposition:
- Width and count macros (DATA_WIDTH, ELEMENT_NUM, LOG2_ELEMENT_NUM) stay in the shared parameter include.
- Add the loader state encoding (LOAD, PAD, START, WAIT) there as localparams/macros so the top-level and the bench can decode state.
- No sub-module: a single FSM plus write-pointer and count registers.

Test Plan:
- Full batch: 16 back-to-back accepts, data 16..1, s_last on beat 16. Required:
  - um_wr_en high 16 cycles, addr 0..15, data 16..1.
  - No pad writes.
  - sort_start single pulse the cycle after the addr-15 write; elem_cnt=16.
- Short batch: 5 elements with s_last on beat 5. Required:
  - Writes at addr 0..4 with data, then addr 5..15 with 8'hFF.
  - s_ready=0 during pad; elem_cnt=5; one sort_start.
- Single element with s_last: elem_cnt=1, 15 pad writes, sort_start after the addr-15 write.
- Backpressure: hold s_valid=1 through WAIT for 10 cycles. Required:
  - s_ready=0 and no writes.
  - sort_done pulse returns the loader to LOAD.
  - The next accept writes addr 0 with elem_cnt=1.
- Reset mid-pad: assert rst during PAD at wr_ptr=9. Required:
  - All outputs 0, state LOAD.
  - No write during the reset cycle.
  - A fresh 16-element batch loads from addr 0.
- Bubbles and spurious done: random s_valid gaps and a sort_done pulse during LOAD. Required:
  - The done pulse is ignored.
  - Addresses stay contiguous.
  - Exactly one sort_start per batch.
